// File: rtl/dsi_lanes_arbiter_pkg.sv
// Shared types and constants for the DSI lane arbiter and its power sequencer.
package dsi_arbiter_pkg;

  // One encoding covers both FSMs: the power sequencer uses OFF..CLK_UP, DOWN
  // and parks in IDLE once the lanes are up; the arbitration FSM uses IDLE,
  // BURST and GAP.
  typedef enum logic [2:0] {
    ST_OFF,
    ST_LINES_UP,
    ST_CLK_DLY,
    ST_CLK_UP,
    ST_IDLE,
    ST_BURST,
    ST_GAP,
    ST_DOWN
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CMD  = 2'b01;
  localparam logic [1:0] GRANT_VID  = 2'b10;

  localparam int GAP_CNT_W    = 8;   // GAP_CYCLES is limited to 1..255
  localparam int PWR_CNT_W    = 16;  // ready timeout and clock delay
  localparam int STARVE_CNT_W = 8;   // saturating port-0 streak

  // Port 0 wins unless port 1 is waiting and has been starved long enough.
  function automatic logic [1:0] pick_winner(input logic r0, input logic r1,
                                             input logic starved);
    if (r1 && (!r0 || starved)) return GRANT_VID;
    if (r0) return GRANT_CMD;
    return GRANT_NONE;
  endfunction

endpackage

// File: rtl/dsi_lanes_arbiter_if.sv
// Word interface shared by the two packet sources and the lanes controller.
//
// Handshake: write_rqst is the valid; while it is high the source holds
// write_data/write_strb/last_word stable. The consumer answers with data_rqst,
// a one-cycle pulse that consumes the current word at that rising edge; the
// source may then present the next word (or drop write_rqst after last_word).
interface dsi_lanes_arbiter_if;
  logic [31:0] write_data;
  logic [3:0]  write_strb;
  logic        write_rqst;
  logic        last_word;
  logic        data_rqst;

  modport master (output write_data, write_strb, write_rqst, last_word,
                  input  data_rqst);
  modport slave  (input  write_data, write_strb, write_rqst, last_word,
                  output data_rqst);
endinterface

// File: rtl/dsi_lanes_arbiter_power_seq.sv
// Lane power sequencer: data lanes first, then the clock lane after a fixed
// delay; orderly power-down that waits for the arbiter to finish its packet.
module dsi_lane_power_seq
  import dsi_arbiter_pkg::*;
#(
  parameter int LINES_TO_CLK_DELAY = 10,
  parameter int READY_TIMEOUT      = 1024
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       lines_ready,
  input  logic       clock_ready,
  input  logic       arb_quiet,
  output logic       lines_enable,
  output logic       clock_enable,
  output logic       timeout_error,
  output logic       power_ok,
  output logic       drain_req,
  output arb_state_t pwr_state
);

  localparam logic [PWR_CNT_W-1:0] TMO_LAST = PWR_CNT_W'(READY_TIMEOUT - 1);
  localparam logic [PWR_CNT_W-1:0] DLY_LAST = PWR_CNT_W'(LINES_TO_CLK_DELAY - 1);

  arb_state_t           state;
  logic [PWR_CNT_W-1:0] cnt;

  // Power FSM with registered lane enables and sticky timeout flag.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_OFF;
      cnt           <= '0;
      lines_enable  <= 1'b0;
      clock_enable  <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      if (!enable) timeout_error <= 1'b0;
      case (state)
        ST_OFF: begin
          cnt <= '0;
          // A timeout blocks restart until enable has been dropped.
          if (enable && !timeout_error) begin
            state        <= ST_LINES_UP;
            lines_enable <= 1'b1;
          end
        end
        ST_LINES_UP: begin
          if (!enable) begin
            state <= ST_DOWN;
          end else if (lines_ready) begin
            state <= ST_CLK_DLY;
            cnt   <= '0;
          end else if (cnt == TMO_LAST) begin
            timeout_error <= 1'b1;
            lines_enable  <= 1'b0;
            cnt           <= '0;
            state         <= ST_OFF;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CLK_DLY: begin
          if (!enable) begin
            state <= ST_DOWN;
          end else if (cnt == DLY_LAST) begin
            state        <= ST_CLK_UP;
            clock_enable <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CLK_UP: begin
          if (!enable) begin
            state <= ST_DOWN;
          end else if (clock_ready) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == TMO_LAST) begin
            timeout_error <= 1'b1;
            lines_enable  <= 1'b0;
            clock_enable  <= 1'b0;
            cnt           <= '0;
            state         <= ST_OFF;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (!enable) state <= ST_DOWN;
        end
        ST_DOWN: begin
          cnt <= '0;
          // Clock lane goes first, and only once no packet is in flight.
          if (clock_enable) begin
            if (arb_quiet) clock_enable <= 1'b0;
          end else if (!clock_ready) begin
            lines_enable <= 1'b0;
            state        <= ST_OFF;
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  assign power_ok  = (state == ST_IDLE) && enable;
  assign drain_req = (state == ST_DOWN);
  assign pwr_state = state;

endmodule

// File: rtl/dsi_lanes_arbiter.sv
// Two-source packet arbiter in front of the DSI lanes controller, with lane
// power sequencing and a programmable inter-packet gap.
module dsi_lanes_arbiter
  import dsi_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES         = 4,
  parameter int LINES_TO_CLK_DELAY = 10,
  parameter int READY_TIMEOUT      = 1024,
  parameter int STARVE_LIMIT       = 8
) (
  input  logic                       clk_sys,
  input  logic                       rst_n,
  input  logic                       enable,
  dsi_lanes_arbiter_if.slave         req0,
  dsi_lanes_arbiter_if.slave         req1,
  dsi_lanes_arbiter_if.master        iface,
  output logic                       lines_enable,
  output logic                       clock_enable,
  input  logic                       lines_ready,
  input  logic                       clock_ready,
  output logic                       busy,
  output logic                       timeout_error,
  output logic [1:0]                 grant,
  output arb_state_t                 dbg_state
);

  localparam logic [GAP_CNT_W-1:0]    GAP_LAST   = GAP_CNT_W'(GAP_CYCLES - 1);
  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_t              arb_state;
  arb_state_t              pwr_state;
  logic [GAP_CNT_W-1:0]    gap_cnt;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    power_ok;
  logic                    drain_req;
  logic                    sel_last;
  logic [1:0]              winner;

  dsi_lane_power_seq #(
    .LINES_TO_CLK_DELAY(LINES_TO_CLK_DELAY),
    .READY_TIMEOUT     (READY_TIMEOUT)
  ) u_power_seq (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .enable       (enable),
    .lines_ready  (lines_ready),
    .clock_ready  (clock_ready),
    .arb_quiet    (grant == GRANT_NONE),
    .lines_enable (lines_enable),
    .clock_enable (clock_enable),
    .timeout_error(timeout_error),
    .power_ok     (power_ok),
    .drain_req    (drain_req),
    .pwr_state    (pwr_state)
  );

  // Arbitration decision for the current IDLE cycle.
  always_comb begin
    winner = pick_winner(req0.write_rqst, req1.write_rqst,
                         starve_cnt >= STARVE_LIM);
  end

  // Arbitration FSM: grant is held for a whole packet, then a gap follows.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      arb_state  <= ST_IDLE;
      grant      <= GRANT_NONE;
      gap_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      case (arb_state)
        ST_IDLE: begin
          if (power_ok && (winner != GRANT_NONE)) begin
            grant     <= winner;
            arb_state <= ST_BURST;
            if (winner == GRANT_VID)
              starve_cnt <= '0;
            else if (starve_cnt != '1)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ST_BURST: begin
          if (iface.data_rqst && sel_last) begin
            grant     <= GRANT_NONE;
            gap_cnt   <= '0;
            arb_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          // A pending power-down abandons the rest of the gap.
          if (drain_req || gap_cnt == GAP_LAST) arb_state <= ST_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: arb_state <= ST_IDLE;
      endcase
    end
  end

  // Zero-latency word mux toward the lanes controller.
  always_comb begin
    iface.write_data = '0;
    iface.write_strb = '0;
    iface.write_rqst = 1'b0;
    iface.last_word  = 1'b0;
    sel_last         = 1'b0;
    if (grant == GRANT_CMD) begin
      iface.write_data = req0.write_data;
      iface.write_strb = req0.write_strb;
      iface.write_rqst = req0.write_rqst;
      iface.last_word  = req0.last_word;
      sel_last         = req0.last_word;
    end else if (grant == GRANT_VID) begin
      iface.write_data = req1.write_data;
      iface.write_strb = req1.write_strb;
      iface.write_rqst = req1.write_rqst;
      iface.last_word  = req1.last_word;
      sel_last         = req1.last_word;
    end
  end

  assign req0.data_rqst = iface.data_rqst & grant[0];
  assign req1.data_rqst = iface.data_rqst & grant[1];
  assign busy           = (arb_state == ST_BURST) || (arb_state == ST_GAP);
  assign dbg_state      = (pwr_state == ST_IDLE) ? arb_state : pwr_state;

endmodule
